// File: rtl/pipe_int_ctrl.sv
// Interrupt and hazard control for a 5-stage pipeline: sequences interrupt entry/return
// and decodes stall, flush and next-PC select from the controller state and hazard inputs.
module pipe_int_ctrl #(
    parameter logic [31:0] HANDLER_VEC = 32'h0000_0100,
    parameter int          CNT_W       = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             irq,
    input  logic             eret_ex,
    input  logic             br_taken_ex,
    input  logic             load_use_hz,
    input  logic [31:0]      ex_pc,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             int_detect,
    output logic             int_return,
    output logic [1:0]       pc_sel,
    output logic [31:0]      epc,
    output logic             irq_ack,
    output logic             in_handler,
    output logic [CNT_W-1:0] int_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE    = 2'd1,
        HANDLER = 2'd2,
        RESTORE = 2'd3
    } state_e;

    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_VEC    = 2'b10;
    localparam logic [1:0] PC_SEL_EPC    = 2'b11;

    // The PC mux outside this block jumps to HANDLER_VEC; it must be a legal fetch address.
    if (HANDLER_VEC[1:0] != 2'b00) begin : g_vec_align
        $error("HANDLER_VEC must be word aligned");
    end

    state_e            state_q, state_d;
    logic [31:0]       epc_q, epc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; Rst is in the sensitivity list because reset is asynchronous.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            epc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        epc_d      = epc_q;
        cnt_d      = cnt_q;
        stall_pc   = 1'b0;
        stall_ifid = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        int_detect = 1'b0;
        int_return = 1'b0;
        irq_ack    = 1'b0;
        pc_sel     = PC_SEL_SEQ;

        unique case (state_q)
            IDLE, HANDLER: begin
                // A resolved branch wins over a load-use stall: the stalled instruction is squashed anyway.
                if (br_taken_ex) begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    pc_sel     = PC_SEL_BRANCH;
                end else if (load_use_hz) begin
                    stall_pc   = 1'b1;
                    stall_ifid = 1'b1;
                    flush_idex = 1'b1;
                end

                if (state_q == IDLE) begin
                    if (irq && !br_taken_ex) begin
                        state_d = SAVE;
                    end
                end else if (eret_ex) begin
                    state_d = RESTORE;
                end
            end

            SAVE: begin
                // Stall/flush stay low here so the stage registers keep the int_detect pulse.
                int_detect = 1'b1;
                irq_ack    = 1'b1;
                pc_sel     = PC_SEL_VEC;
                epc_d      = ex_pc;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                state_d    = HANDLER;
            end

            RESTORE: begin
                int_return = 1'b1;
                pc_sel     = PC_SEL_EPC;
                state_d    = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign epc        = epc_q;
    assign int_count  = cnt_q;
    assign in_handler = (state_q == HANDLER);

endmodule

// File: tb/tb_pipe_int_ctrl.sv
// Directed bench for pipe_int_ctrl: interrupt entry/return, branch and load-use hazards,
// reset in mid-sequence and service-counter saturation, with hand-computed expectations.
module tb_pipe_int_ctrl;

    localparam int CNT_W = 8;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             irq, eret_ex, br_taken_ex, load_use_hz;
    logic [31:0]      ex_pc;
    logic             stall_pc, stall_ifid, flush_ifid, flush_idex;
    logic             int_detect, int_return, irq_ack, in_handler;
    logic [1:0]       pc_sel;
    logic [31:0]      epc;
    logic [CNT_W-1:0] int_count;

    int n_checks = 0;
    int n_errors = 0;

    pipe_int_ctrl #(.HANDLER_VEC(32'h0000_0100), .CNT_W(CNT_W)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .irq         (irq),
        .eret_ex     (eret_ex),
        .br_taken_ex (br_taken_ex),
        .load_use_hz (load_use_hz),
        .ex_pc       (ex_pc),
        .stall_pc    (stall_pc),
        .stall_ifid  (stall_ifid),
        .flush_ifid  (flush_ifid),
        .flush_idex  (flush_idex),
        .int_detect  (int_detect),
        .int_return  (int_return),
        .pc_sel      (pc_sel),
        .epc         (epc),
        .irq_ack     (irq_ack),
        .in_handler  (in_handler),
        .int_count   (int_count)
    );

    always #5 Clk = ~Clk;

    // Control bundle: {stall_pc, stall_ifid, flush_ifid, flush_idex,
    //                  int_detect, int_return, irq_ack, in_handler, pc_sel[1:0]}
    localparam logic [9:0] C_NONE    = 10'b0000_0000_00;
    localparam logic [9:0] C_SAVE    = 10'b0000_1010_10;
    localparam logic [9:0] C_RESTORE = 10'b0000_0100_11;
    localparam logic [9:0] C_HANDLER = 10'b0000_0001_00;
    localparam logic [9:0] C_LU      = 10'b1101_0000_00;
    localparam logic [9:0] C_BR      = 10'b0011_0000_01;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ctrl();
        return {22'd0, stall_pc, stall_ifid, flush_ifid, flush_idex,
                int_detect, int_return, irq_ack, in_handler, pc_sel};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Apply inputs just after an edge and let the combinational outputs settle.
    task automatic drive(input logic i, input logic e, input logic b, input logic l);
        irq         = i;
        eret_ex     = e;
        br_taken_ex = b;
        load_use_hz = l;
        #1;
    endtask

    initial begin
        Rst = 1'b1;
        ex_pc = 32'h0;
        drive(0, 0, 0, 0);
        #10;
        check("reset_ctrl", ctrl(), {22'd0, C_NONE});
        check("reset_epc", epc, 32'h0);
        check("reset_cnt", {24'd0, int_count}, 32'd0);

        // Interrupt entry from IDLE
        tick();
        Rst = 1'b0;
        ex_pc = 32'h0000_0040;
        drive(1, 0, 0, 0);
        check("idle_irq_ctrl", ctrl(), {22'd0, C_NONE});
        tick();
        drive(1, 0, 0, 0);
        check("save_ctrl", ctrl(), {22'd0, C_SAVE});
        check("save_epc_unchanged", epc, 32'h0);
        tick();
        ex_pc = 32'h0000_0099;
        drive(1, 0, 0, 0);
        check("handler_ctrl", ctrl(), {22'd0, C_HANDLER});
        check("handler_epc", epc, 32'h0000_0040);
        check("handler_cnt", {24'd0, int_count}, 32'd1);
        tick();
        drive(1, 0, 0, 0);
        check("no_nesting_ctrl", ctrl(), {22'd0, C_HANDLER});
        check("epc_held", epc, 32'h0000_0040);
        drive(1, 0, 0, 1);
        check("handler_lu_ctrl", ctrl(), {22'd0, C_LU | C_HANDLER});

        // eret together with a branch: flush now, RESTORE next
        drive(1, 1, 1, 0);
        check("handler_eret_br", ctrl(), {22'd0, C_BR | C_HANDLER});
        tick();
        ex_pc = 32'h0000_0080;
        drive(1, 0, 1, 1);
        check("restore_hazard_ctrl", ctrl(), {22'd0, C_RESTORE});
        tick();
        drive(1, 0, 0, 0);
        check("post_restore_idle", ctrl(), {22'd0, C_NONE});
        check("epc_after_restore", epc, 32'h0000_0040);
        tick();
        drive(1, 0, 1, 1);
        check("save_hazard_ctrl", ctrl(), {22'd0, C_SAVE});
        tick();
        drive(0, 1, 0, 0);
        check("second_epc", epc, 32'h0000_0080);
        check("second_cnt", {24'd0, int_count}, 32'd2);
        check("handler_eret_ctrl", ctrl(), {22'd0, C_HANDLER});
        tick();
        drive(0, 0, 0, 0);
        check("restore_ctrl", ctrl(), {22'd0, C_RESTORE});
        tick();

        // Branch and irq together in IDLE: branch first, irq taken a cycle later
        drive(1, 0, 1, 0);
        check("idle_irq_br", ctrl(), {22'd0, C_BR});
        tick();
        drive(1, 0, 0, 0);
        check("idle_after_br", ctrl(), {22'd0, C_NONE});
        tick();
        drive(1, 0, 0, 0);
        check("save_after_br", ctrl(), {22'd0, C_SAVE});
        tick();
        drive(0, 0, 0, 0);
        check("third_cnt", {24'd0, int_count}, 32'd3);

        // Reset while in HANDLER
        Rst = 1'b1;
        #1;
        check("rst_handler_ctrl", ctrl(), {22'd0, C_NONE});
        check("rst_handler_cnt", {24'd0, int_count}, 32'd0);
        check("rst_handler_epc", epc, 32'h0);
        tick();
        Rst = 1'b0;

        // Load-use for two cycles, then load-use with a branch
        drive(0, 0, 0, 1);
        check("lu_cycle1", ctrl(), {22'd0, C_LU});
        tick();
        drive(0, 0, 0, 1);
        check("lu_cycle2", ctrl(), {22'd0, C_LU});
        drive(0, 0, 1, 1);
        check("lu_with_br", ctrl(), {22'd0, C_BR});
        tick();

        // Reset while in SAVE: no return pulse, counter not advanced
        drive(1, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0);
        check("save_before_rst", ctrl(), {22'd0, C_SAVE});
        Rst = 1'b1;
        #1;
        check("rst_save_ctrl", ctrl(), {22'd0, C_NONE});
        check("rst_save_cnt", {24'd0, int_count}, 32'd0);

        // Saturation: irq and eret held high give one interrupt every 4 cycles
        tick();
        Rst = 1'b0;
        ex_pc = 32'h0000_1234;
        drive(1, 1, 0, 0);
        for (int i = 0; i < 400; i++) tick();
        check("cnt_after_100", {24'd0, int_count}, 32'd100);
        for (int i = 0; i < 800; i++) tick();
        check("cnt_saturated", {24'd0, int_count}, 32'd255);
        check("sat_idle_ctrl", ctrl(), {22'd0, C_NONE});
        check("sat_epc", epc, 32'h0000_1234);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
